// File: rtl/data_packet_sender.sv
// Frame-to-packet serializer: one PKT_W packet per beat, first packet visible the cycle after frame accept.
// Holds data_pkt/last_data_packet while pkt_ready is low; frame_ready only in IDLE, optional idle gap between frames.
module data_packet_sender #(
  parameter int PKT_W          = 4,
  parameter int PKTS_PER_FRAME = 4,
  parameter int GAP_CYCLES     = 2,
  parameter bit REVERSE        = 1'b0
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [PKT_W*PKTS_PER_FRAME-1:0] frame_data,
  input  logic                            frame_valid,
  output logic                            frame_ready,
  output logic [PKT_W-1:0]                data_pkt,
  output logic                            pkt_valid,
  input  logic                            pkt_ready,
  output logic                            last_data_packet,
  output logic                            busy,
  output logic [15:0]                     frame_count
);

  localparam int FW    = PKT_W * PKTS_PER_FRAME;
  localparam int CNT_W = (PKTS_PER_FRAME > 1) ? $clog2(PKTS_PER_FRAME) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKTS_PER_FRAME - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t             state_q, state_d;
  logic [FW-1:0]      shreg_q, shreg_d;
  logic [CNT_W-1:0]   beat_q, beat_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [PKT_W-1:0]   pkt_q, pkt_d;
  logic               vld_q, vld_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic               xfer;

  function automatic logic [PKT_W-1:0] orient(input logic [PKT_W-1:0] p);
    logic [PKT_W-1:0] r;
    r = p;
    if (REVERSE) begin
      for (int i = 0; i < PKT_W; i++) r[i] = p[PKT_W-1-i];
    end
    return r;
  endfunction

  assign xfer = vld_q && pkt_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      beat_q        <= '0;
      gap_q         <= '0;
      pkt_q         <= '0;
      vld_q         <= 1'b0;
      last_q        <= 1'b0;
      busy_q        <= 1'b0;
      frame_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      beat_q        <= beat_d;
      gap_q         <= gap_d;
      pkt_q         <= pkt_d;
      vld_q         <= vld_d;
      last_q        <= last_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_valid) state_d = SEND;
      SEND:    if (xfer && beat_q == '0) state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:     if (gap_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // shreg holds only the packets not yet presented; packet 0 goes straight to pkt_q
  always_comb begin
    shreg_d       = shreg_q;
    beat_d        = beat_q;
    gap_d         = gap_q;
    pkt_d         = pkt_q;
    vld_d         = vld_q;
    last_d        = last_q;
    frame_count_d = frame_count_q;
    busy_d        = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (frame_valid) begin
          shreg_d = frame_data >> PKT_W;
          pkt_d   = orient(frame_data[PKT_W-1:0]);
          vld_d   = 1'b1;
          last_d  = (PKTS_PER_FRAME == 1);
          beat_d  = LAST_BEAT;
        end
      end
      SEND: begin
        if (xfer) begin
          if (beat_q == '0) begin
            vld_d         = 1'b0;
            last_d        = 1'b0;
            frame_count_d = frame_count_q + 16'd1;
            gap_d         = GAP_LOAD;
          end else begin
            pkt_d   = orient(shreg_q[PKT_W-1:0]);
            shreg_d = shreg_q >> PKT_W;
            beat_d  = beat_q - 1'b1;
            last_d  = (beat_q == CNT_W'(1));
          end
        end
      end
      GAP: begin
        if (gap_q != '0) gap_d = gap_q - 1'b1;
      end
      default: ;
    endcase
  end

  assign frame_ready      = (state_q == IDLE);
  assign data_pkt         = pkt_q;
  assign pkt_valid        = vld_q;
  assign last_data_packet = last_q;
  assign busy             = busy_q;
  assign frame_count      = frame_count_q;

endmodule

// File: tb/tb_data_packet_sender.sv
// Directed bench for data_packet_sender: three instances cover default, bit-reversed and single-packet/no-gap builds.
module tb_data_packet_sender;

  logic clock;
  logic reset;

  logic [15:0] a_fd;  logic a_fv, a_fr, a_pv, a_pr, a_last, a_busy;  logic [3:0] a_pkt;  logic [15:0] a_cnt;
  logic [15:0] b_fd;  logic b_fv, b_fr, b_pv, b_pr, b_last, b_busy;  logic [3:0] b_pkt;  logic [15:0] b_cnt;
  logic [3:0]  c_fd;  logic c_fv, c_fr, c_pv, c_pr, c_last, c_busy;  logic [3:0] c_pkt;  logic [15:0] c_cnt;

  int checks = 0;
  int passed = 0;

  data_packet_sender #(.PKT_W(4), .PKTS_PER_FRAME(4), .GAP_CYCLES(2), .REVERSE(1'b0)) dut_a (
    .clock(clock), .reset(reset), .frame_data(a_fd), .frame_valid(a_fv), .frame_ready(a_fr),
    .data_pkt(a_pkt), .pkt_valid(a_pv), .pkt_ready(a_pr), .last_data_packet(a_last),
    .busy(a_busy), .frame_count(a_cnt));

  data_packet_sender #(.PKT_W(4), .PKTS_PER_FRAME(4), .GAP_CYCLES(2), .REVERSE(1'b1)) dut_b (
    .clock(clock), .reset(reset), .frame_data(b_fd), .frame_valid(b_fv), .frame_ready(b_fr),
    .data_pkt(b_pkt), .pkt_valid(b_pv), .pkt_ready(b_pr), .last_data_packet(b_last),
    .busy(b_busy), .frame_count(b_cnt));

  data_packet_sender #(.PKT_W(4), .PKTS_PER_FRAME(1), .GAP_CYCLES(0), .REVERSE(1'b0)) dut_c (
    .clock(clock), .reset(reset), .frame_data(c_fd), .frame_valid(c_fv), .frame_ready(c_fr),
    .data_pkt(c_pkt), .pkt_valid(c_pv), .pkt_ready(c_pr), .last_data_packet(c_last),
    .busy(c_busy), .frame_count(c_cnt));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_fd = '0; a_fv = 0; a_pr = 0;
    b_fd = '0; b_fv = 0; b_pr = 0;
    c_fd = '0; c_fv = 0; c_pr = 0;
    #12;
    checks++; if ({a_pkt, a_pv, a_last, a_busy} !== 7'b0) $display("FAIL reset_a_outs got %b want 0", {a_pkt, a_pv, a_last, a_busy}); else passed++;
    checks++; if (a_cnt !== 16'h0000) $display("FAIL reset_a_cnt got %h want 0000", a_cnt); else passed++;
    checks++; if ({c_pkt, c_pv, c_last, c_busy} !== 7'b0) $display("FAIL reset_c_outs got %b want 0", {c_pkt, c_pv, c_last, c_busy}); else passed++;
    @(negedge clock);
    reset = 1'b0;
    step();
    checks++; if ({a_fr, b_fr, c_fr} !== 3'b111) $display("FAIL reset_frame_ready got %b want 111", {a_fr, b_fr, c_fr}); else passed++;
  endtask

  task automatic test_async_reset();
    a_fd = 16'h4321; a_fv = 1; a_pr = 1;
    step();
    a_fv = 0;
    checks++; if (a_pkt !== 4'h1) $display("FAIL arst_p1 got %h want 1", a_pkt); else passed++;
    step();
    a_pr = 0;
    checks++; if ({a_pv, a_pkt} !== 5'b1_0010) $display("FAIL arst_p2 got %b want 10010", {a_pv, a_pkt}); else passed++;
    #3 reset = 1'b1;
    #1;
    checks++; if ({a_pv, a_last, a_busy} !== 3'b000) $display("FAIL arst_drop got %b want 000", {a_pv, a_last, a_busy}); else passed++;
    checks++; if (a_cnt !== 16'h0000) $display("FAIL arst_cnt got %h want 0000", a_cnt); else passed++;
    checks++; if (a_pkt !== 4'h0) $display("FAIL arst_pkt got %h want 0", a_pkt); else passed++;
    #2 reset = 1'b0;
    checks++; if (a_fr !== 1'b1) $display("FAIL arst_ready got %b want 1", a_fr); else passed++;
    step();
    a_fd = 16'h8765; a_fv = 1; a_pr = 1;
    step();
    a_fv = 0;
    for (int k = 0; k < 4; k++) begin
      checks++; if ({a_pv, a_pkt, a_last} !== {1'b1, 4'(k + 5), (k == 3)})
        $display("FAIL arst_restart_%0d got %b want %b", k, {a_pv, a_pkt, a_last}, {1'b1, 4'(k + 5), (k == 3)}); else passed++;
      step();
    end
    step(); step();
    checks++; if ({a_fr, a_cnt} !== {1'b1, 16'h0001}) $display("FAIL arst_done got %b/%h want 1/0001", a_fr, a_cnt); else passed++;
  endtask

  task automatic test_single_frame();
    a_fd = 16'h4321; a_fv = 1; a_pr = 1;
    step();
    a_fv = 0;
    for (int k = 0; k < 6; k++) begin
      checks++; if (a_fr !== 1'b0) $display("FAIL single_ready_%0d got %b want 0", k, a_fr); else passed++;
      if (k < 4) begin
        checks++; if ({a_pv, a_pkt, a_last} !== {1'b1, 4'(k + 1), (k == 3)})
          $display("FAIL single_pkt_%0d got %b want %b", k, {a_pv, a_pkt, a_last}, {1'b1, 4'(k + 1), (k == 3)}); else passed++;
      end else if (k == 4) begin
        checks++; if ({a_pv, a_last, a_cnt} !== {2'b00, 16'h0002}) $display("FAIL single_end got %b/%h want 00/0002", {a_pv, a_last}, a_cnt); else passed++;
      end
      step();
    end
    checks++; if ({a_fr, a_busy} !== 2'b10) $display("FAIL single_idle got %b want 10", {a_fr, a_busy}); else passed++;
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_p [7];
    logic       rdy   [7];
    exp_p = '{4'h1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h3, 4'h4};
    rdy   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    a_fd = 16'h4321; a_fv = 1; a_pr = 1;
    step();
    a_fv = 0;
    for (int k = 0; k < 7; k++) begin
      a_pr = rdy[k];
      checks++; if ({a_pv, a_pkt, a_last} !== {1'b1, exp_p[k], (k == 6)})
        $display("FAIL bp_cycle_%0d got %b want %b", k, {a_pv, a_pkt, a_last}, {1'b1, exp_p[k], (k == 6)}); else passed++;
      step();
    end
    checks++; if ({a_pv, a_cnt} !== {1'b0, 16'h0003}) $display("FAIL bp_end got %b/%h want 0/0003", a_pv, a_cnt); else passed++;
    step(); step();
    checks++; if (a_fr !== 1'b1) $display("FAIL bp_idle got %b want 1", a_fr); else passed++;
  endtask

  task automatic test_reverse();
    logic [15:0] frames [2];
    logic [15:0] exp_s  [2];
    frames = '{16'h0081, 16'h0801};
    exp_s  = '{16'h0018, 16'h0108};
    for (int f = 0; f < 2; f++) begin
      b_fd = frames[f]; b_fv = 1; b_pr = 1;
      step();
      b_fv = 0;
      for (int k = 0; k < 4; k++) begin
        checks++; if ({b_pv, b_pkt, b_last} !== {1'b1, exp_s[f][4*k +: 4], (k == 3)})
          $display("FAIL rev_f%0d_p%0d got %b want %b", f, k, {b_pv, b_pkt, b_last}, {1'b1, exp_s[f][4*k +: 4], (k == 3)}); else passed++;
        step();
      end
      checks++; if ({b_pv, b_cnt} !== {1'b0, 16'(f + 1)}) $display("FAIL rev_end_%0d got %b/%h want 0/%h", f, b_pv, b_cnt, 16'(f + 1)); else passed++;
      step(); step();
      checks++; if ({b_fr, b_busy} !== 2'b10) $display("FAIL rev_idle_%0d got %b want 10", f, {b_fr, b_busy}); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    c_pr = 1; c_fd = 4'hA; c_fv = 1;
    step();
    checks++; if ({c_pv, c_pkt, c_last, c_fr, c_busy} !== 8'b1_1010_1_0_1) $display("FAIL b2b_first got %b want 11010101", {c_pv, c_pkt, c_last, c_fr, c_busy}); else passed++;
    c_fd = 4'h5;
    step();
    checks++; if ({c_pv, c_last, c_fr, c_cnt} !== {3'b001, 16'h0001}) $display("FAIL b2b_gap got %b/%h want 001/0001", {c_pv, c_last, c_fr}, c_cnt); else passed++;
    step();
    c_fv = 0;
    checks++; if ({c_pv, c_pkt, c_last} !== 6'b1_0101_1) $display("FAIL b2b_second got %b want 101011", {c_pv, c_pkt, c_last}); else passed++;
    step();
    checks++; if ({c_pv, c_fr, c_cnt} !== {2'b01, 16'h0002}) $display("FAIL b2b_end got %b/%h want 01/0002", {c_pv, c_fr}, c_cnt); else passed++;
  endtask

  task automatic test_count_wrap();
    force dut_c.frame_count_q = 16'hFFFF;
    #1;
    release dut_c.frame_count_q;
    checks++; if (c_cnt !== 16'hFFFF) $display("FAIL wrap_preset got %h want ffff", c_cnt); else passed++;
    step();
    c_fd = 4'h3; c_fv = 1; c_pr = 1;
    step();
    c_fv = 0;
    checks++; if ({c_pv, c_pkt, c_last} !== 6'b1_0011_1) $display("FAIL wrap_pkt got %b want 100111", {c_pv, c_pkt, c_last}); else passed++;
    step();
    checks++; if ({c_pv, c_cnt} !== {1'b0, 16'h0000}) $display("FAIL wrap_cnt got %b/%h want 0/0000", c_pv, c_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_single_frame();
    test_backpressure();
    test_reverse();
    test_back_to_back();
    test_count_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout after 50000 time units, %0d/%0d so far", passed, checks);
    $fatal(1, "timeout");
  end

endmodule
